fetch_issue: RTL and testbench

FETCH_ISSUE -- requirements
Module: fetch_issue

---
 rtl/fetch_issue_pkg.sv | 37 +++
 rtl/issue_width_dec.sv | 21 ++
 rtl/fetch_issue.sv | 177 +++++++++++++++++
 tb/tb_fetch_issue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_issue_pkg.sv
// Shared definitions for the fetch-to-decode issue stage: default constants,
// FSM state encoding and the issue-slot record held in the output register.
package fetch_issue_pkg;

    localparam logic [31:0] INST_NOP_DEFAULT = 32'h0340_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h1c00_0000;

    // PAIR: issue a whole packet (or its first half); SECOND: inst1 of a split packet pending
    typedef enum logic [0:0] {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic        valid0;
        logic        valid1;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] pc0;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
    } issue_slot_t;

    // Contents of the output register when no slot is valid
    function automatic issue_slot_t empty_slot(input logic [31:0] nop, input logic [31:0] pc_rst);
        issue_slot_t s;
        s.valid0    = 1'b0;
        s.valid1    = 1'b0;
        s.inst0     = nop;
        s.inst1     = nop;
        s.pc0       = pc_rst;
        s.exception = 7'd0;
        s.excp_flag = 2'd0;
        return s;
    endfunction

endpackage

// File: rtl/issue_width_dec.sv
// Decides whether the fetch-buffer head packet may issue both instructions.
// A packet is two-wide only when it starts on an 8-byte boundary, carries no
// fetch exception, inst0 is not predicted taken, and the predicted next PC is
// not the sequential pc+4.
module issue_width_dec (
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_next_i,
    input  logic [1:0]  excp_flag_i,
    input  logic        taken0_i,
    output logic        two_wide_o,
    output logic [31:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + 32'd4;

    assign two_wide_o = (pc_i[2] == 1'b0)
                     && (excp_flag_i == 2'b00)
                     && (taken0_i == 1'b0)
                     && (pc_next_i != pc_plus4_o);

endmodule

// File: rtl/fetch_issue.sv
// Fetch-to-decode issue stage. Pops packets from the fetch buffer into a
// two-slot output register feeding decode. Packets holding a privileged
// instruction that would otherwise issue as a pair are split over two cycles.
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter logic [31:0] INST_NOP = INST_NOP_DEFAULT,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        fifo_valid,
    output logic        fifo_ready,
    input  logic [31:0] fifo_inst0,
    input  logic [31:0] fifo_inst1,
    input  logic [31:0] fifo_pc,
    input  logic [31:0] fifo_pc_next,
    input  logic [6:0]  fifo_exception,
    input  logic [1:0]  fifo_excp_flag,
    input  logic [1:0]  fifo_priv_flag,
    input  logic [1:0]  fifo_branch_flag,
    input  logic        id_allowin,
    output logic        id_valid0,
    output logic        id_valid1,
    output logic [31:0] id_inst0,
    output logic [31:0] id_inst1,
    output logic [31:0] id_pc0,
    output logic [6:0]  id_exception,
    output logic [1:0]  id_excp_flag
);

    issue_state_e state_q;
    issue_state_e state_d;
    issue_slot_t  slot_q;
    issue_slot_t  slot_d;

    logic         two_wide_s;
    logic [31:0]  pc_plus4_s;
    logic         advance_s;
    logic         split_s;
    logic         unused_branch1_s;

    // Only inst0's taken prediction affects pairing
    assign unused_branch1_s = fifo_branch_flag[1];

    issue_width_dec u_width_dec (
        .pc_i        (fifo_pc),
        .pc_next_i   (fifo_pc_next),
        .excp_flag_i (fifo_excp_flag),
        .taken0_i    (fifo_branch_flag[0]),
        .two_wide_o  (two_wide_s),
        .pc_plus4_o  (pc_plus4_s)
    );

    // Output register may load when it is empty or decode takes its contents
    assign advance_s = !(slot_q.valid0 || slot_q.valid1) || id_allowin;

    // A pairable packet containing a privileged instruction issues one at a time
    assign split_s = fifo_valid && two_wide_s && (fifo_priv_flag != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_PAIR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush and reset always return to PAIR
    always_comb begin
        state_d = state_q;
        if (!rstn || flush) begin
            state_d = ST_PAIR;
        end else if (advance_s) begin
            case (state_q)
                ST_PAIR: begin
                    if (split_s) begin
                        state_d = ST_SECOND;
                    end else begin
                        state_d = ST_PAIR;
                    end
                end
                ST_SECOND: begin
                    if (fifo_valid) begin
                        state_d = ST_PAIR;
                    end else begin
                        state_d = ST_SECOND;
                    end
                end
                default: begin
                    state_d = ST_PAIR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output logic: next output-register contents and the buffer pop strobe
    always_comb begin
        slot_d     = slot_q;
        fifo_ready = 1'b0;
        if (!rstn || flush) begin
            slot_d = empty_slot(INST_NOP, PC_RESET);
        end else if (advance_s) begin
            case (state_q)
                ST_PAIR: begin
                    if (fifo_valid) begin
                        slot_d.valid0    = 1'b1;
                        slot_d.inst0     = fifo_inst0;
                        slot_d.pc0       = fifo_pc;
                        slot_d.excp_flag = fifo_excp_flag;
                        if (fifo_excp_flag != 2'b00) begin
                            slot_d.exception = fifo_exception;
                        end else begin
                            slot_d.exception = 7'd0;
                        end
                        if (two_wide_s && !split_s) begin
                            slot_d.valid1 = 1'b1;
                            slot_d.inst1  = fifo_inst1;
                            fifo_ready    = 1'b1;
                        end else if (split_s) begin
                            slot_d.valid1 = 1'b0;
                            slot_d.inst1  = INST_NOP;
                            fifo_ready    = 1'b0;
                        end else begin
                            slot_d.valid1 = 1'b0;
                            slot_d.inst1  = INST_NOP;
                            fifo_ready    = 1'b1;
                        end
                    end else begin
                        slot_d = empty_slot(INST_NOP, PC_RESET);
                    end
                end
                ST_SECOND: begin
                    if (fifo_valid) begin
                        slot_d.valid0    = 1'b1;
                        slot_d.valid1    = 1'b0;
                        slot_d.inst0     = fifo_inst1;
                        slot_d.inst1     = INST_NOP;
                        slot_d.pc0       = pc_plus4_s;
                        slot_d.exception = 7'd0;
                        slot_d.excp_flag = 2'd0;
                        fifo_ready       = 1'b1;
                    end else begin
                        slot_d = empty_slot(INST_NOP, PC_RESET);
                    end
                end
                default: begin
                    slot_d = empty_slot(INST_NOP, PC_RESET);
                end
            endcase
        end else begin
            slot_d = slot_q;
        end
    end

    // Output register towards decode
    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_q <= empty_slot(INST_NOP, PC_RESET);
        end else begin
            slot_q <= slot_d;
        end
    end

    assign id_valid0    = slot_q.valid0;
    assign id_valid1    = slot_q.valid1;
    assign id_inst0     = slot_q.inst0;
    assign id_inst1     = slot_q.inst1;
    assign id_pc0       = slot_q.pc0;
    assign id_exception = slot_q.exception;
    assign id_excp_flag = slot_q.excp_flag;

endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: directed scenarios followed by a randomized run
// checked against a packet-level reference model.
module tb_fetch_issue;

    localparam logic [31:0] NOP  = 32'h0340_0000;
    localparam logic [31:0] PCR  = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn, flush, fifo_valid, fifo_ready, id_allowin;
    logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag, fifo_priv_flag, fifo_branch_flag;
    logic        id_valid0, id_valid1;
    logic [31:0] id_inst0, id_inst1, id_pc0;
    logic [6:0]  id_exception;
    logic [1:0]  id_excp_flag;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] i0, i1, pc, pcn;
        logic [6:0]  exc;
        logic [1:0]  ef, pf, bf;
    } pkt_t;

    typedef struct {
        logic        v0, v1;
        logic [31:0] i0, i1, pc0;
        logic [6:0]  exc;
        logic [1:0]  fl;
    } exp_t;

    exp_t m_out;
    int   m_idx;
    pkt_t pkt_q[$];

    always #5 clk = ~clk;

    fetch_issue dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1),
        .fifo_pc(fifo_pc), .fifo_pc_next(fifo_pc_next),
        .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag),
        .fifo_priv_flag(fifo_priv_flag), .fifo_branch_flag(fifo_branch_flag),
        .id_allowin(id_allowin),
        .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_inst0(id_inst0), .id_inst1(id_inst1), .id_pc0(id_pc0),
        .id_exception(id_exception), .id_excp_flag(id_excp_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [31:0] i0, input logic [31:0] i1,
                                input logic [31:0] pc, input logic [31:0] pcn,
                                input logic [6:0] exc, input logic [1:0] ef,
                                input logic [1:0] pf, input logic [1:0] bf);
        pkt_t p;
        p.i0 = i0; p.i1 = i1; p.pc = pc; p.pcn = pcn;
        p.exc = exc; p.ef = ef; p.pf = pf; p.bf = bf;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        int   sel;
        p.i0  = $urandom;
        p.i1  = $urandom;
        p.pc  = 32'h1c00_0000 + ($urandom_range(0, 255) * 4);
        sel   = $urandom_range(0, 2);
        p.pcn = (sel == 0) ? p.pc + 32'd4 : (sel == 1) ? p.pc + 32'd8 : 32'h1c00_0000 + ($urandom_range(0, 255) * 4);
        p.ef  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        p.exc = 7'($urandom);
        p.pf  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        p.bf  = 2'($urandom_range(0, 3));
        return p;
    endfunction

    function automatic exp_t empty_exp();
        exp_t e;
        e.v0 = 1'b0; e.v1 = 1'b0; e.i0 = NOP; e.i1 = NOP; e.pc0 = PCR; e.exc = 7'd0; e.fl = 2'd0;
        return e;
    endfunction

    task automatic drive_pkt(input pkt_t p);
        fifo_inst0 = p.i0; fifo_inst1 = p.i1; fifo_pc = p.pc; fifo_pc_next = p.pcn;
        fifo_exception = p.exc; fifo_excp_flag = p.ef; fifo_priv_flag = p.pf; fifo_branch_flag = p.bf;
    endtask

    // Check the pop strobe for the current inputs, then let one clock edge pass
    task automatic go(input string tag, input logic exp_ready);
        #1;
        chk({tag, "_ready"}, 32'(fifo_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input exp_t e);
        chk({tag, "_v0"},  32'(id_valid0),    32'(e.v0));
        chk({tag, "_v1"},  32'(id_valid1),    32'(e.v1));
        chk({tag, "_i0"},  id_inst0,          e.i0);
        chk({tag, "_i1"},  id_inst1,          e.i1);
        chk({tag, "_pc0"}, id_pc0,            e.pc0);
        chk({tag, "_exc"}, 32'(id_exception), 32'(e.exc));
        chk({tag, "_fl"},  32'(id_excp_flag), 32'(e.fl));
    endtask

    function automatic exp_t ex(input logic v0, input logic v1, input logic [31:0] i0,
                                input logic [31:0] i1, input logic [31:0] pc0,
                                input logic [6:0] exc, input logic [1:0] fl);
        exp_t e;
        e.v0 = v0; e.v1 = v1; e.i0 = i0; e.i1 = i1; e.pc0 = pc0; e.exc = exc; e.fl = fl;
        return e;
    endfunction

    // Packet-level model: each head packet yields a list of issue groups;
    // the head is popped once its last group has been issued.
    task automatic model_step(input pkt_t p, input logic fv, input logic al, input logic fl,
                              output logic rdy);
        logic adv, wide;
        int   ng;
        adv = !(m_out.v0 || m_out.v1) || al;
        rdy = 1'b0;
        if (fl) begin
            m_out = empty_exp();
            m_idx = 0;
        end else if (!adv) begin
            rdy = 1'b0;
        end else if (!fv) begin
            m_out = empty_exp();
        end else begin
            wide  = ((p.pc % 32'd8) == 32'd0) && (p.ef == 2'd0) && (p.bf[0] == 1'b0) && (p.pcn != p.pc + 32'd4);
            ng    = (wide && p.pf != 2'd0) ? 2 : 1;
            m_out = empty_exp();
            m_out.v0 = 1'b1;
            if (m_idx == 0) begin
                m_out.i0  = p.i0;
                m_out.pc0 = p.pc;
                if (p.ef != 2'd0) begin
                    m_out.exc = p.exc;
                    m_out.fl  = p.ef;
                end
                if (wide && p.pf == 2'd0) begin
                    m_out.v1 = 1'b1;
                    m_out.i1 = p.i1;
                end
            end else begin
                m_out.i0  = p.i1;
                m_out.pc0 = p.pc + 32'd4;
            end
            rdy   = (m_idx == ng - 1);
            m_idx = rdy ? 0 : m_idx + 1;
        end
    endtask

    initial begin
        logic fv, al, fl, rdy;
        exp_t hold;

        // Reset with a packet present: no pop, outputs in reset state
        rstn = 1'b0; flush = 1'b0; id_allowin = 1'b1; fifo_valid = 1'b1;
        drive_pkt(mk(32'h1111_0000, 32'h1111_0004, 32'h1c00_0000, 32'h1c00_0008, 7'd0, 2'd0, 2'd0, 2'd0));
        go("rst0", 1'b0);
        go("rst1", 1'b0);
        expect_out("rst", empty_exp());

        // Aligned two-wide packet issues as a pair
        rstn = 1'b1;
        go("pair", 1'b1);
        expect_out("pair", ex(1'b1, 1'b1, 32'h1111_0000, 32'h1111_0004, 32'h1c00_0000, 7'd0, 2'd0));

        // Empty buffer on advance clears the slots
        fifo_valid = 1'b0;
        go("drain", 1'b0);
        expect_out("drain", empty_exp());

        // Misaligned packet is one-wide
        fifo_valid = 1'b1;
        drive_pkt(mk(32'h2222_0000, 32'h2222_0004, 32'h1c00_0004, 32'h1c00_0008, 7'd0, 2'd0, 2'd0, 2'd0));
        go("odd", 1'b1);
        expect_out("odd", ex(1'b1, 1'b0, 32'h2222_0000, NOP, 32'h1c00_0004, 7'd0, 2'd0));

        // Privileged inst1 forces a split over two cycles
        drive_pkt(mk(32'h3333_0000, 32'h3333_0004, 32'h1c00_0000, 32'h1c00_0008, 7'd0, 2'd0, 2'b10, 2'd0));
        go("split1", 1'b0);
        expect_out("split1", ex(1'b1, 1'b0, 32'h3333_0000, NOP, 32'h1c00_0000, 7'd0, 2'd0));
        go("split2", 1'b1);
        hold = ex(1'b1, 1'b0, 32'h3333_0004, NOP, 32'h1c00_0004, 7'd0, 2'd0);
        expect_out("split2", hold);

        // Decode stall holds outputs and blocks popping
        drive_pkt(mk(32'h4444_0000, 32'h4444_0004, 32'h1c00_0010, 32'h1c00_0018, 7'd0, 2'd0, 2'd0, 2'd0));
        id_allowin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            go("stall", 1'b0);
            expect_out("stall", hold);
        end
        id_allowin = 1'b1;
        go("unstall", 1'b1);
        expect_out("unstall", ex(1'b1, 1'b1, 32'h4444_0000, 32'h4444_0004, 32'h1c00_0010, 7'd0, 2'd0));

        // Flush in the second half of a split restarts the packet from inst0
        drive_pkt(mk(32'h5555_0000, 32'h5555_0004, 32'h1c00_0020, 32'h1c00_0028, 7'd0, 2'd0, 2'b01, 2'd0));
        go("fsplit", 1'b0);
        expect_out("fsplit", ex(1'b1, 1'b0, 32'h5555_0000, NOP, 32'h1c00_0020, 7'd0, 2'd0));
        flush = 1'b1;
        go("flush", 1'b0);
        expect_out("flush", empty_exp());
        flush = 1'b0;
        go("reissue1", 1'b0);
        expect_out("reissue1", ex(1'b1, 1'b0, 32'h5555_0000, NOP, 32'h1c00_0020, 7'd0, 2'd0));
        go("reissue2", 1'b1);
        expect_out("reissue2", ex(1'b1, 1'b0, 32'h5555_0004, NOP, 32'h1c00_0024, 7'd0, 2'd0));

        // Reset in the middle of a split drops the pending inst1
        drive_pkt(mk(32'h6666_0000, 32'h6666_0004, 32'h1c00_0030, 32'h1c00_0038, 7'd0, 2'd0, 2'b10, 2'd0));
        go("rsplit", 1'b0);
        rstn = 1'b0;
        go("rmid", 1'b0);
        expect_out("rmid", empty_exp());
        rstn = 1'b1;
        go("rrestart", 1'b0);
        expect_out("rrestart", ex(1'b1, 1'b0, 32'h6666_0000, NOP, 32'h1c00_0030, 7'd0, 2'd0));
        go("rsecond", 1'b1);

        // Exception packet issues alone with its exception in slot 0
        drive_pkt(mk(32'h7777_0000, 32'h7777_0004, 32'h1c00_0040, 32'h1c00_0048, 7'h08, 2'b01, 2'd0, 2'd0));
        go("excp", 1'b1);
        expect_out("excp", ex(1'b1, 1'b0, 32'h7777_0000, NOP, 32'h1c00_0040, 7'h08, 2'b01));

        // Predicted-taken inst0 and sequential next PC both give one-wide
        drive_pkt(mk(32'h8888_0000, 32'h8888_0004, 32'h1c00_0050, 32'h1c00_0058, 7'h11, 2'd0, 2'd0, 2'b01));
        go("taken", 1'b1);
        expect_out("taken", ex(1'b1, 1'b0, 32'h8888_0000, NOP, 32'h1c00_0050, 7'd0, 2'd0));
        drive_pkt(mk(32'h9999_0000, 32'h9999_0004, 32'h1c00_0060, 32'h1c00_0064, 7'd0, 2'd0, 2'd0, 2'd0));
        go("seq", 1'b1);
        expect_out("seq", ex(1'b1, 1'b0, 32'h9999_0000, NOP, 32'h1c00_0060, 7'd0, 2'd0));

        // Randomized run against the model, starting from a reset
        rstn = 1'b0;
        go("rrst", 1'b0);
        rstn  = 1'b1;
        m_out = empty_exp();
        m_idx = 0;
        for (int k = 0; k < 4; k++) pkt_q.push_back(rand_pkt());
        for (int c = 0; c < 800; c++) begin
            fv = ($urandom_range(0, 3) != 0);
            al = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            drive_pkt(pkt_q[0]);
            fifo_valid = fv; id_allowin = al; flush = fl;
            model_step(pkt_q[0], fv, al, fl, rdy);
            go("rnd", rdy);
            expect_out("rnd", m_out);
            if (rdy) begin
                pkt_q.delete(0);
                pkt_q.push_back(rand_pkt());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
